// File: rtl/l2_tlb_search_ctrl.sv
// ---------------------------------------------------------------------------
// l2_tlb_search_ctrl
//
// Controls one dual-port L2 TLB check RAM.
// - Lookups: the set index comes from the lookup address. The controller sweeps
//   every offset of that set. Each cycle it reads half 0 on port 0 and half 1
//   on port 1. It stops at the first hit, or declares a miss after the last
//   offset has been compared. The response is then held until it is consumed.
// - Config writes: single-cycle writes into the RAM through port 0. They are
//   accepted only in IDLE, and they win over a lookup offered in the same cycle.
//
// Handshakes: a transfer on lookup_*, cfg_* or resp_* happens in any cycle
// where valid and ready are both high at the rising clock edge. A valid
// request must stay stable until it is accepted. resp_valid_o stays high, with
// stable fields, until resp_ready_i is seen.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   lookup_*                 lookup request (address, read/write type)
//   cfg_*                    config write request (RAM address, data)
//   resp_*                   held lookup response
//   ram_we_o .. offset_addr_d_o   control and addresses driven to the check RAM
//   hit_i .. hit_addr_i      compare results from the check RAM (1-cycle latency)
//   dbg_state_o              current FSM state (0 IDLE, 1 SEARCH, 2 DONE)
// ---------------------------------------------------------------------------
module l2_tlb_search_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int PAGE_SIZE    = 4096,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4,
  localparam int IGNORE_LSB  = $clog2(PAGE_SIZE),
  localparam int RAM_AW      = SET_WIDTH + OFFSET_WIDTH + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    lookup_valid_i,
  output logic                    lookup_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  input  logic                    lookup_rw_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [RAM_AW-1:0]       cfg_addr_i,
  input  logic [31:0]             cfg_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_hit_o,
  output logic                    resp_multi_o,
  output logic                    resp_prot_o,
  output logic                    resp_master_o,
  output logic [RAM_AW-1:0]       resp_hit_addr_o,
  output logic                    ram_we_o,
  output logic [RAM_AW-1:0]       port0_addr_o,
  output logic [RAM_AW-1:0]       port1_addr_o,
  output logic [31:0]             ram_wdata_o,
  output logic [ADDR_WIDTH-1:0]   in_addr_o,
  output logic                    rw_type_o,
  output logic                    searching_o,
  output logic                    start_search_o,
  output logic                    send_outputs_o,
  output logic [OFFSET_WIDTH-1:0] offset_addr_d_o,
  input  logic                    hit_i,
  input  logic                    multi_hit_i,
  input  logic                    prot_i,
  input  logic                    master_i,
  input  logic [RAM_AW-1:0]       hit_addr_i,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [OFFSET_WIDTH-1:0] CNT_MAX = {OFFSET_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rw_q;
  logic [SET_WIDTH-1:0]    set_q;
  logic [OFFSET_WIDTH-1:0] cnt_q;
  logic                    issue_q;   // cnt_q is an offset still to be issued
  logic                    search_q;  // RAM compare result is valid this cycle
  logic [OFFSET_WIDTH-1:0] off_d_q;
  logic                    last_d_q;  // the compare this cycle is for the last offset
  logic                    hit_q, multi_q, prot_q, master_q;
  logic [RAM_AW-1:0]       hit_addr_q;

  logic lookup_fire;
  logic search_end;

  assign lookup_fire = lookup_valid_i & lookup_ready_o;
  // A hit on the last-offset compare wins over the miss.
  assign search_end  = search_q & (hit_i | last_d_q);

  // ---- state register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (lookup_fire)  state_d = S_SEARCH;
      S_SEARCH: if (search_end)   state_d = S_DONE;
      S_DONE:   if (resp_ready_i) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // ---- datapath: request capture, offset sweep, result capture ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      rw_q       <= 1'b0;
      set_q      <= '0;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      search_q   <= 1'b0;
      off_d_q    <= '0;
      last_d_q   <= 1'b0;
      hit_q      <= 1'b0;
      multi_q    <= 1'b0;
      prot_q     <= 1'b0;
      master_q   <= 1'b0;
      hit_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lookup_fire) begin
            addr_q   <= lookup_addr_i;
            rw_q     <= lookup_rw_i;
            set_q    <= lookup_addr_i[IGNORE_LSB +: SET_WIDTH];
            cnt_q    <= '0;
            issue_q  <= 1'b1;
            search_q <= 1'b0;
            last_d_q <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (search_end) begin
            issue_q    <= 1'b0;
            search_q   <= 1'b0;
            hit_q      <= hit_i;
            multi_q    <= hit_i & multi_hit_i;
            prot_q     <= hit_i & prot_i;
            master_q   <= hit_i & master_i;
            hit_addr_q <= hit_i ? hit_addr_i : '0;
          end else begin
            // The compare for an offset arrives one cycle after the offset is issued.
            search_q <= issue_q;
            if (issue_q) begin
              off_d_q  <= cnt_q;
              last_d_q <= (cnt_q == CNT_MAX);
              // The counter stops at the last offset; it never wraps.
              if (cnt_q == CNT_MAX) issue_q <= 1'b0;
              else                  cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- outputs ----
  always_comb begin
    lookup_ready_o  = 1'b0;
    cfg_ready_o     = 1'b0;
    ram_we_o        = 1'b0;
    port0_addr_o    = '0;
    port1_addr_o    = '0;
    ram_wdata_o     = '0;
    start_search_o  = 1'b0;
    send_outputs_o  = 1'b0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_multi_o    = 1'b0;
    resp_prot_o     = 1'b0;
    resp_master_o   = 1'b0;
    resp_hit_addr_o = '0;
    case (state_q)
      S_IDLE: begin
        // The readies are gated by reset so that every output reads 0 while reset is held.
        if (rst_ni) begin
          cfg_ready_o    = 1'b1;
          lookup_ready_o = ~cfg_valid_i;
          if (cfg_valid_i) begin
            ram_we_o     = 1'b1;
            port0_addr_o = cfg_addr_i;
            ram_wdata_o  = cfg_wdata_i;
          end
        end
      end
      S_SEARCH: begin
        if (issue_q) begin
          port0_addr_o   = {1'b0, set_q, cnt_q};
          port1_addr_o   = {1'b1, set_q, cnt_q};
          start_search_o = (cnt_q == '0);
        end
      end
      S_DONE: begin
        resp_valid_o    = 1'b1;
        resp_hit_o      = hit_q;
        resp_multi_o    = multi_q;
        resp_prot_o     = prot_q;
        resp_master_o   = master_q;
        resp_hit_addr_o = hit_addr_q;
        send_outputs_o  = resp_ready_i;
      end
      default: ;
    endcase
  end

  assign in_addr_o       = addr_q;
  assign rw_type_o       = rw_q;
  assign searching_o     = search_q;
  assign offset_addr_d_o = off_d_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_l2_tlb_search_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for l2_tlb_search_ctrl.
// The check RAM is modelled as 1024 x 32-bit entries with a 1-cycle read.
// Entry format: [31:12] VPN, [3] master, [1] writable, [0] valid.
// An entry hits when it is valid and its VPN equals in_addr_o[31:12].
// A write access to an entry that is not writable is a protection violation.
// When both halves hit, half 0 is reported.
// ---------------------------------------------------------------------------
module tb_l2_tlb_search_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid, lookup_ready, lookup_rw;
  logic [31:0] lookup_addr;
  logic        cfg_valid, cfg_ready;
  logic [9:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        resp_valid, resp_ready, resp_hit, resp_multi, resp_prot, resp_master;
  logic [9:0]  resp_hit_addr;
  logic        ram_we;
  logic [9:0]  port0_addr, port1_addr;
  logic [31:0] ram_wdata, in_addr;
  logic        rw_type, searching, start_search, send_outputs;
  logic [3:0]  offset_d;
  logic        hit, multi_hit, prot, master;
  logic [9:0]  hit_addr;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  l2_tlb_search_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_rw_i(lookup_rw),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hit_o(resp_hit), .resp_multi_o(resp_multi), .resp_prot_o(resp_prot),
    .resp_master_o(resp_master), .resp_hit_addr_o(resp_hit_addr),
    .ram_we_o(ram_we), .port0_addr_o(port0_addr), .port1_addr_o(port1_addr),
    .ram_wdata_o(ram_wdata), .in_addr_o(in_addr), .rw_type_o(rw_type),
    .searching_o(searching), .start_search_o(start_search),
    .send_outputs_o(send_outputs), .offset_addr_d_o(offset_d),
    .hit_i(hit), .multi_hit_i(multi_hit), .prot_i(prot), .master_i(master),
    .hit_addr_i(hit_addr), .dbg_state_o(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- check RAM model ----
  logic [31:0] mem [0:1023];
  logic        clr_req;
  logic [9:0]  p0_q, p1_q;
  logic [31:0] e0, e1;
  logic        h0, h1;

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[port0_addr] <= ram_wdata;
    end
    p0_q <= port0_addr;
    p1_q <= port1_addr;
  end

  always_comb begin
    e0 = mem[p0_q];
    e1 = mem[p1_q];
    h0 = e0[0] && (e0[31:12] == in_addr[31:12]);
    h1 = e1[0] && (e1[31:12] == in_addr[31:12]);
    hit       = h0 | h1;
    multi_hit = h0 & h1;
    hit_addr  = h0 ? p0_q : (h1 ? p1_q : 10'd0);
    master    = h0 ? e0[3] : (h1 ? e1[3] : 1'b0);
    prot      = h0 ? (rw_type & ~e0[1]) : (h1 ? (rw_type & ~e1[1]) : 1'b0);
  end

  logic [109:0] all_out;
  assign all_out = {lookup_ready, cfg_ready, resp_valid, resp_hit, resp_multi, resp_prot,
                    resp_master, resp_hit_addr, ram_we, port0_addr, port1_addr, ram_wdata,
                    in_addr, rw_type, searching, start_search, send_outputs, offset_d};

  // ---- scoreboard ----
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic clear_ram();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic cfg_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_wdata = d;
    #1 check("cfg_we", {ram_we, port0_addr, ram_wdata}, {1'b1, a, d});
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Returns the cycle, relative to the accept cycle T, in which resp_valid rises.
  task automatic do_lookup(input logic [31:0] a, input logic rw,
                           output int lat, output logic saw_we, output int starts);
    @(negedge clk);
    lookup_valid = 1'b1; lookup_addr = a; lookup_rw = rw;
    #1 check("lookup_ready_idle", lookup_ready, 1'b1);
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    lat = 1;
    saw_we = ram_we;
    starts = int'(start_search);
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      saw_we = saw_we | ram_we;
      starts += int'(start_search);
    end
  endtask

  task automatic reset_pulse_check(input string name);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check({name, "_outs_zero"}, all_out, 110'd0);
    check({name, "_state"}, dbg_state, 2'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({name, "_idle_after"}, {dbg_state, resp_valid, searching, lookup_ready, cfg_ready},
          {2'd0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  // ---- directed vectors ----
  typedef struct {
    logic [4:0] set;
    logic       half;
    logic       dual;
    logic [3:0] off;
    logic [3:0] flags;
    logic       vpn_bad;
    logic       wr_entry;
    logic       rw;
    int         exp_lat;
    logic       exp_hit, exp_multi, exp_prot, exp_master;
    logic [9:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] make_addr(input logic [4:0] s);
    return {15'h2A5C, s, 12'h3C4};
  endfunction

  initial begin
    int          lat, starts;
    logic        saw_we;
    logic [31:0] a, entry;
    logic [9:0]  ea;

    //        set  hf dl off flags    bad wr rw  lat hit mul prt mst addr
    vecs[0] = '{5'd3,  0, 0, 4'd0,  4'b0011, 0, 1, 0,  3, 1, 0, 0, 0, 10'h030};
    vecs[1] = '{5'd3,  1, 0, 4'd9,  4'b1001, 0, 1, 0, 12, 1, 0, 0, 1, 10'h239};
    vecs[2] = '{5'd7,  0, 0, 4'd0,  4'b0000, 0, 0, 0, 18, 0, 0, 0, 0, 10'h000};
    vecs[3] = '{5'd3,  0, 1, 4'd2,  4'b0001, 0, 1, 1,  5, 1, 1, 1, 0, 10'h032};
    vecs[4] = '{5'd31, 1, 0, 4'd15, 4'b1011, 0, 1, 1, 18, 1, 0, 0, 1, 10'h3FF};
    vecs[5] = '{5'd0,  0, 0, 4'd5,  4'b0011, 1, 1, 0, 18, 0, 0, 0, 0, 10'h000};
    vecs[6] = '{5'd20, 0, 0, 4'd1,  4'b0011, 0, 1, 1,  4, 1, 0, 0, 0, 10'h141};

    // ---- clock/reset ----
    rst_n = 1'b0;
    lookup_valid = 1'b0; lookup_addr = '0; lookup_rw = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    resp_ready = 1'b0; clr_req = 1'b0;
    #1 check("reset_outs_zero", all_out, 110'd0);
    check("reset_state", dbg_state, 2'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_readies", {cfg_ready, lookup_ready, ram_we}, 3'b110);

    // ---- table-driven lookups ----
    for (int v = 0; v < 7; v++) begin
      clear_ram();
      a = make_addr(vecs[v].set);
      if (vecs[v].wr_entry) begin
        entry = {a[31:12] ^ {19'd0, vecs[v].vpn_bad}, 8'd0, vecs[v].flags};
        ea = {vecs[v].half, vecs[v].set, vecs[v].off};
        cfg_write(ea, entry);
        if (vecs[v].dual) cfg_write({~vecs[v].half, vecs[v].set, vecs[v].off}, entry);
      end
      do_lookup(a, vecs[v].rw, lat, saw_we, starts);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_resp", v),
            {resp_valid, resp_hit, resp_multi, resp_prot, resp_master, resp_hit_addr},
            {1'b1, vecs[v].exp_hit, vecs[v].exp_multi, vecs[v].exp_prot,
             vecs[v].exp_master, vecs[v].exp_addr});
      check($sformatf("v%0d_no_we", v), saw_we, 1'b0);
      check($sformatf("v%0d_one_start", v), starts, 1);
      check($sformatf("v%0d_in_addr", v), {in_addr, rw_type}, {a, vecs[v].rw});
      // The response must be held while resp_ready is low; nothing is accepted in DONE.
      @(posedge clk); #1;
      check($sformatf("v%0d_hold", v),
            {resp_valid, resp_hit, resp_hit_addr, lookup_ready, cfg_ready},
            {1'b1, vecs[v].exp_hit, vecs[v].exp_addr, 1'b0, 1'b0});
      @(negedge clk); resp_ready = 1'b1;
      #1 check($sformatf("v%0d_send", v), send_outputs, 1'b1);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check($sformatf("v%0d_back_idle", v), {resp_valid, lookup_ready, dbg_state},
            {1'b0, 1'b1, 2'd0});
    end

    // ---- config write wins over a simultaneous lookup ----
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = 10'h155; cfg_wdata = 32'hDEAD_BEE1;
    lookup_valid = 1'b1; lookup_addr = make_addr(5'd9); lookup_rw = 1'b0;
    #1 check("cfg_win", {cfg_ready, lookup_ready, ram_we, port0_addr, ram_wdata},
             {1'b1, 1'b0, 1'b1, 10'h155, 32'hDEAD_BEE1});
    @(negedge clk);
    cfg_valid = 1'b0; lookup_valid = 1'b0;
    #1 check("cfg_no_state_change", {dbg_state, searching, ram_we}, {2'd0, 1'b0, 1'b0});

    // ---- reset in the middle of a search ----
    clear_ram();
    @(negedge clk);
    lookup_valid = 1'b1; lookup_addr = make_addr(5'd12); lookup_rw = 1'b1;
    @(posedge clk); #1 lookup_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("mid_search_active", {dbg_state, searching}, {2'd1, 1'b1});
    reset_pulse_check("rst_search");

    // ---- reset while a response is held ----
    clear_ram();
    a = make_addr(5'd4);
    cfg_write({1'b0, 5'd4, 4'd0}, {a[31:12], 12'h00B});
    do_lookup(a, 1'b0, lat, saw_we, starts);
    check("done_before_rst", {resp_valid, resp_hit, resp_master}, 3'b111);
    reset_pulse_check("rst_done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
